note_sequencer: RTL and testbench

//   Upstream stage of the programmable tone divider (e-organ path). Selects the note divisor k for the divider.

---
 rtl/note_pkg.sv | 47 ++++
 rtl/key_debounce.sv | 55 +++++
 rtl/note_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_note_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared note codes, divisor table and sequencer FSM state type for the e-organ note path.
// Divisors assume a 1 MHz tone clock: k = round(1e6/(2f)) - 1.
package note_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D4   = 4'd2;
    localparam logic [3:0] NOTE_E4   = 4'd3;
    localparam logic [3:0] NOTE_F4   = 4'd4;
    localparam logic [3:0] NOTE_G4   = 4'd5;
    localparam logic [3:0] NOTE_A4   = 4'd6;
    localparam logic [3:0] NOTE_B4   = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_e;

    function automatic logic [12:0] note_k(input logic [3:0] code);
        case (code)
            NOTE_C4: note_k = 13'd1910;
            NOTE_D4: note_k = 13'd1702;
            NOTE_E4: note_k = 13'd1516;
            NOTE_F4: note_k = 13'd1431;
            NOTE_G4: note_k = 13'd1275;
            NOTE_A4: note_k = 13'd1135;
            NOTE_B4: note_k = 13'd1011;
            NOTE_C5: note_k = 13'd955;
            default: note_k = 13'd0;
        endcase
    endfunction

    // Scanning downwards leaves the lowest set key as the winner.
    function automatic logic [3:0] lowest_code(input logic [7:0] v);
        lowest_code = NOTE_REST;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                lowest_code = 4'(i + 1);
            end else begin
                lowest_code = lowest_code;
            end
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stability counter; dout holds the last vector
// that was seen for CYCLES consecutive samples.
module key_debounce #(
    parameter int CYCLES = 20000,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int              CNT_W    = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt counts identical samples of cand including the first one.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q >= CNT_LAST) begin
            stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchronizer and debounce state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/note_sequencer.sv
// Note divisor selection: debounced manual keys or song-ROM playback (IDLE/PLAY/GAP).
// Optional `NOTE_SEQ_LOOP_EN adds a `loop` input that restarts the song after the last step.
module note_sequencer
    import note_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int BEAT_CYCLES     = 250000,
    parameter int GAP_CYCLES      = 20000,
    parameter int SONG_LEN        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  keys,
    input  logic        auto_mode,
    input  logic        start,
`ifdef NOTE_SEQ_LOOP_EN
    input  logic        loop,
`endif
    output logic [12:0] k,
    output logic        sound_en,
    output logic [3:0]  note_code,
    output logic        busy
);

    localparam int IDX_W   = $clog2(SONG_LEN);
    localparam int CYC_MAX = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SONG_LEN - 1);
    localparam logic [CYC_W-1:0] BEAT_LOAD = CYC_W'(BEAT_CYCLES - 1);
    localparam logic [CYC_W-1:0] GAP_LOAD  = CYC_W'(GAP_CYCLES - 1);

    function automatic logic [5:0] song_rom(input logic [3:0] addr);
        case (addr)
            4'd0:    song_rom = {2'd1, NOTE_C4};
            4'd1:    song_rom = {2'd0, NOTE_E4};
            4'd2:    song_rom = {2'd0, 4'd12};
            4'd3:    song_rom = {2'd1, NOTE_G4};
            4'd4:    song_rom = {2'd0, NOTE_A4};
            4'd5:    song_rom = {2'd0, NOTE_G4};
            4'd6:    song_rom = {2'd1, NOTE_E4};
            4'd7:    song_rom = {2'd0, NOTE_F4};
            4'd8:    song_rom = {2'd0, NOTE_D4};
            4'd9:    song_rom = {2'd1, NOTE_C4};
            4'd10:   song_rom = {2'd0, NOTE_C5};
            4'd11:   song_rom = {2'd0, NOTE_B4};
            4'd12:   song_rom = {2'd1, NOTE_A4};
            4'd13:   song_rom = {2'd0, NOTE_G4};
            4'd14:   song_rom = {2'd0, NOTE_E4};
            4'd15:   song_rom = {2'd2, NOTE_C5};
            default: song_rom = {2'd0, NOTE_REST};
        endcase
    endfunction

    logic [7:0]       deb_s;
    logic             loop_s;
    logic [IDX_W-1:0] load_idx_s;
    logic [5:0]       rom_word_s;
    logic [3:0]       step_code_s;
    logic [3:0]       man_code_s;

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       beat_q, beat_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [12:0]      k_q, k_d;
    logic             snd_q, snd_d;
    logic [3:0]       code_q, code_d;
    logic             busy_q, busy_d;

    key_debounce #(
        .CYCLES (DEBOUNCE_CYCLES),
        .WIDTH  (8)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (keys),
        .dout  (deb_s)
    );

`ifdef NOTE_SEQ_LOOP_EN
    assign loop_s = loop;
`else
    assign loop_s = 1'b0;
`endif

    // Step about to be loaded: 0 when starting or wrapping, else the next index.
    always_comb begin
        if ((state_q == ST_GAP) && (idx_q != LAST_IDX)) begin
            load_idx_s = idx_q + IDX_W'(1);
        end else begin
            load_idx_s = '0;
        end
        rom_word_s = song_rom(4'(load_idx_s));
        if (rom_word_s[3:0] > NOTE_C5) begin
            step_code_s = NOTE_REST;
        end else begin
            step_code_s = rom_word_s[3:0];
        end
        man_code_s = lowest_code(deb_s);
    end

    // Next-state and next-output logic; outputs are registered alongside the state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        cyc_d   = cyc_q;
        k_d     = k_q;
        snd_d   = snd_q;
        code_d  = code_q;
        busy_d  = busy_q;
        if (!auto_mode) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            beat_d  = 2'd0;
            cyc_d   = '0;
            busy_d  = 1'b0;
            code_d  = man_code_s;
            k_d     = note_k(man_code_s);
            snd_d   = (man_code_s != NOTE_REST);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_PLAY;
                        idx_d   = load_idx_s;
                        beat_d  = rom_word_s[5:4];
                        cyc_d   = BEAT_LOAD;
                        code_d  = step_code_s;
                        k_d     = note_k(step_code_s);
                        snd_d   = (step_code_s != NOTE_REST);
                        busy_d  = 1'b1;
                    end else begin
                        k_d    = 13'd0;
                        snd_d  = 1'b0;
                        code_d = NOTE_REST;
                        busy_d = 1'b0;
                    end
                end
                ST_PLAY: begin
                    busy_d = 1'b1;
                    if (cyc_q != '0) begin
                        cyc_d = cyc_q - CYC_W'(1);
                    end else if (beat_q != 2'd0) begin
                        beat_d = beat_q - 2'd1;
                        cyc_d  = BEAT_LOAD;
                    end else begin
                        state_d = ST_GAP;
                        cyc_d   = GAP_LOAD;
                        snd_d   = 1'b0;
                    end
                end
                ST_GAP: begin
                    snd_d = 1'b0;
                    if (cyc_q != '0) begin
                        cyc_d = cyc_q - CYC_W'(1);
                    end else if ((idx_q == LAST_IDX) && !loop_s) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        k_d     = 13'd0;
                        code_d  = NOTE_REST;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_PLAY;
                        idx_d   = load_idx_s;
                        beat_d  = rom_word_s[5:4];
                        cyc_d   = BEAT_LOAD;
                        code_d  = step_code_s;
                        k_d     = note_k(step_code_s);
                        snd_d   = (step_code_s != NOTE_REST);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    k_d     = 13'd0;
                    snd_d   = 1'b0;
                    code_d  = NOTE_REST;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            beat_q  <= 2'd0;
            cyc_q   <= '0;
            k_q     <= 13'd0;
            snd_q   <= 1'b0;
            code_q  <= NOTE_REST;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            cyc_q   <= cyc_d;
            k_q     <= k_d;
            snd_q   <= snd_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
        end
    end

    assign k         = k_q;
    assign sound_en  = snd_q;
    assign note_code = code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: table-driven manual-key vectors plus hand-written
// song playback, start/auto_mode corner cases and async reset (loop test under NOTE_SEQ_LOOP_EN).
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  keys;
    logic        auto_mode;
    logic        start;
    logic [12:0] k;
    logic        sound_en;
    logic [3:0]  note_code;
    logic        busy;
`ifdef NOTE_SEQ_LOOP_EN
    logic        loop;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        logic [7:0] keys;
        int         ticks;
        int         ek;
        int         ecode;
        int         esnd;
    } vec_t;

    vec_t vecs[12];

    // Song schedule for the first four ROM steps: C4 x2 beats, E4, rest (code 12), G4 x2 beats.
    int sk[4]    = '{1910, 1516, 0, 1275};
    int scode[4] = '{1, 3, 0, 5};
    int ssnd[4]  = '{1, 1, 0, 1};
    int slen[4]  = '{20, 10, 10, 20};

    note_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .BEAT_CYCLES     (10),
        .GAP_CYCLES      (2),
        .SONG_LEN        (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .keys      (keys),
        .auto_mode (auto_mode),
        .start     (start),
`ifdef NOTE_SEQ_LOOP_EN
        .loop      (loop),
`endif
        .k         (k),
        .sound_en  (sound_en),
        .note_code (note_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input int ek, input int ecode,
                              input int esnd, input int ebusy, input bit chk_code);
        check({name, ".k"}, int'(k), ek);
        check({name, ".sound_en"}, int'(sound_en), esnd);
        check({name, ".busy"}, int'(busy), ebusy);
        if (chk_code) check({name, ".note_code"}, int'(note_code), ecode);
    endtask

    // Check the expected outputs, then advance one clock, n times.
    task automatic play_check(input string name, input int n, input int ek, input int ecode,
                              input int esnd, input int ebusy, input bit chk_code);
        for (int i = 0; i < n; i++) begin
            check_outs(name, ek, ecode, esnd, ebusy, chk_code);
            tick();
        end
    endtask

    task automatic run_song();
        for (int s = 0; s < 4; s++) begin
            play_check($sformatf("play%0d", s), slen[s], sk[s], scode[s], ssnd[s], 1, 1'b1);
            play_check($sformatf("gap%0d", s), 2, sk[s], 0, 0, 1, 1'b0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        keys      = 8'h00;
        auto_mode = 1'b0;
        start     = 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
        loop      = 1'b0;
`endif
        // Key changes appear on the outputs 7 edges later: 2 sync + 4 stable samples + 1 register.
        vecs[0]  = '{"key04_early", 8'h04, 6, 0,    0, 0};
        vecs[1]  = '{"key04",       8'h04, 1, 1516, 3, 1};
        vecs[2]  = '{"key88_early", 8'h88, 6, 1516, 3, 1};
        vecs[3]  = '{"key88",       8'h88, 1, 1431, 4, 1};
        vecs[4]  = '{"release",     8'h00, 7, 0,    0, 0};
        vecs[5]  = '{"key80",       8'h80, 7, 955,  8, 1};
        vecs[6]  = '{"key02",       8'h02, 7, 1702, 2, 1};
        vecs[7]  = '{"key40",       8'h40, 7, 1011, 7, 1};
        vecs[8]  = '{"key20",       8'h20, 7, 1135, 6, 1};
        vecs[9]  = '{"key10",       8'h10, 7, 1275, 5, 1};
        vecs[10] = '{"keyff",       8'hff, 7, 1910, 1, 1};
        vecs[11] = '{"release2",    8'h00, 7, 0,    0, 0};

        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0, 1'b1);
        rst_n = 1'b1;

        for (int v = 0; v < 12; v++) begin
            keys = vecs[v].keys;
            repeat (vecs[v].ticks) tick();
            check_outs(vecs[v].name, vecs[v].ek, vecs[v].ecode, vecs[v].esnd, 0, 1'b1);
        end

        // Bouncing key never holds 4 samples: outputs must stay silent.
        for (int i = 0; i < 24; i++) begin
            keys = ((i / 2) % 2 == 0) ? 8'h01 : 8'h00;
            check_outs("bounce", 0, 0, 0, 0, 1'b1);
            tick();
        end
        keys = 8'h00;
        play_check("bounce_settle", 7, 0, 0, 0, 0, 1'b1);

        // Auto mode idle: keys are ignored while the debouncer keeps tracking them.
        keys      = 8'h04;
        auto_mode = 1'b1;
        tick();
        play_check("auto_idle", 10, 0, 0, 0, 0, 1'b1);

        start = 1'b1;
        tick();
        start = 1'b0;
        run_song();
        play_check("song_end", 3, 0, 0, 0, 0, 1'b1);

        // start with auto_mode=0 is ignored.
        auto_mode = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start     = 1'b0;
        auto_mode = 1'b1;
        tick();
        play_check("start_manual", 2, 0, 0, 0, 0, 1'b1);

        // start while busy must not restart step 0's timer.
        start = 1'b1;
        tick();
        start = 1'b0;
        play_check("busy_a", 5, 1910, 1, 1, 1, 1'b1);
        start = 1'b1;
        play_check("busy_start", 1, 1910, 1, 1, 1, 1'b1);
        start = 1'b0;
        play_check("busy_b", 14, 1910, 1, 1, 1, 1'b1);
        play_check("busy_gap", 2, 1910, 0, 0, 1, 1'b0);
        play_check("busy_step1", 4, 1516, 3, 1, 1, 1'b1);

        // Dropping auto_mode mid-song returns to the debounced keys (8'h04 -> E4) on the next edge.
        auto_mode = 1'b0;
        tick();
        check_outs("auto_drop", 1516, 3, 1, 0, 1'b1);
        auto_mode = 1'b1;
        tick();
        check_outs("auto_back", 0, 0, 0, 0, 1'b1);

`ifdef NOTE_SEQ_LOOP_EN
        loop  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_song();
        play_check("loop_step0", 12, 1910, 1, 1, 1, 1'b1);
`else
        start = 1'b1;
        tick();
        start = 1'b0;
        play_check("pre_reset", 12, 1910, 1, 1, 1, 1'b1);
`endif

        // Asynchronous reset mid-song clears outputs without waiting for an edge.
        rst_n = 1'b0;
        #2;
        check_outs("async_reset", 0, 0, 0, 0, 1'b1);
        tick();
        check_outs("held_reset", 0, 0, 0, 0, 1'b1);
        rst_n = 1'b1;
        play_check("post_reset", 3, 0, 0, 0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
